intersection_controller: RTL and testbench
==========================================

// Module: intersection_controller
// PURPOSE
//  Sequences a two-approach intersection: main road (NS) and side street (EW).
//  NS rests in green. EW is served only on demand: a vehicle sensor or a latched
//  pedestrian request. An all-red clearance interval separates every handover.
//  An emergency preempt input drives the intersection safely back to NS green.
//  Sits above the per-lamp driver logic; all lamp outputs are produced here.
// PARAMETERS
//  CNT_W         5   phase counter width (each limit below must fit)
//  NS_GREEN_MIN  10  NS green minimum; dwell = value+1 cycles before EW can be served
//  EW_GREEN      8   EW green dwell = value+1 cycles (fixed)
//  YELLOW_T      2   yellow dwell = value+1 cycles (both approaches)
//  ALL_RED_T     1   all-red clearance dwell = value+1 cycles
// PORTS
//  clk          in   1  single clock; all state updates on posedge
//  reset        in   1  synchronous, active-high
//  ew_car       in   1  level; vehicle present on EW approach
//  ped_req      in   1  one-cycle pulse; pedestrian button to cross the NS road
//  preempt      in   1  level; emergency vehicle needs NS green
//  ns_red/ns_yellow/ns_green  out 1 each  NS lamps, exactly one high
//  ew_red/ew_yellow/ew_green  out 1 each  EW lamps, exactly one high
//  walk         out  1  pedestrian walk lamp (crossing NS road)
//  ped_wait     out  1  pedestrian request pending, not yet served
// BEHAVIOUR
//  - States: NS_GRN, NS_YEL, RED_A (after NS), EW_GRN, EW_YEL, RED_B (after EW).
//  - Reset: state=RED_B, counter=0, ped pending=0.
//    Outputs under reset: ns_red=1, ew_red=1, all other lamps 0, walk=0, ped_wait=0.
//  - Outputs: Moore decode of the state register; no extra latency.
//    walk=1 only in EW_GRN. ped_wait = pending bit.
//  - Counter rules:
//    - Clears to 0 on every state change.
//    - Otherwise increments while below the state's limit.
//    - In NS_GRN it saturates at NS_GREEN_MIN; no wrap in any state.
//  - Transitions (at counter==limit unless noted):
//    - RED_B -> NS_GRN.
//    - NS_GRN -> NS_YEL when counter==NS_GREEN_MIN and demand and !preempt.
//      demand = ew_car | pending. With no demand, NS_GRN holds indefinitely.
//    - NS_YEL -> RED_A -> EW_GRN -> EW_YEL -> RED_B.
//    - preempt=1 in EW_GRN: EW_YEL on the next edge, regardless of counter.
//    - preempt=1 in NS_YEL, RED_A, EW_YEL or RED_B: no shortcut, normal timing.
//      Clearance is never skipped.
//    - preempt=1 in RED_A: proceeds to EW_GRN, then exits EW_GRN on the next edge.
//  - Pedestrian pending bit:
//    - Set on ped_req in any state except EW_GRN; ped_req during EW_GRN is ignored.
//    - Cleared on the edge entering EW_GRN.
//    - Set and clear on the same edge (ped_req while RED_A->EW_GRN): clear wins.
//  - Safety invariant: never ns_green|ns_yellow together with ew_green|ew_yellow.
//    Every green follows an all-red state.
//  - Reset mid-phase: immediate return to RED_B with counter 0; pending is dropped.
//  - Illegal state encoding: recover to RED_B on the next edge with all lamps red.
// STRUCTURE
//  - Shared package traffic_pkg:
//    - phase_t enum (6 states, 3-bit).
//    - Lamp-vector constants LAMP_R/LAMP_Y/LAMP_G.
//    - Default timing constants.
//  - One sub-module: phase_timer (CNT_W counter with clear, limit input,
//    saturate, done flag). Instantiated once; the FSM drives the per-state limit.
// TESTING
//  1. Reset, ew_car=0, ped_req=0 -> 2 cycles all-red, then NS green held >= 100 cycles.
//  2. ew_car=1 held from reset -> repeating 30-cycle loop:
//     NS_GRN 11, NS_YEL 3, RED_A 2, EW_GRN 9, EW_YEL 3, RED_B 2.
//  3. ped_req pulse at NS green cycle 3, ew_car=0 -> ped_wait=1 until EW_GRN entry.
//     NS green lasts 11 cycles total. walk=1 for 9 cycles, ped_wait 0 during walk.
//  4. ped_req pulse during EW_GRN -> ignored: ped_wait stays 0 and the next NS green
//     holds without demand.
//  5. preempt=1 at EW_GRN cycle 2 -> EW_YEL on the next edge, then 3 + 2 cycles to
//     NS_GRN. With preempt held, NS_GRN holds despite ew_car=1.
//  6. reset asserted during EW_YEL with ped pending -> next cycle all-red, ped_wait=0.
//     Every cycle of every test checks the safety invariant.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and default timing for the two-approach intersection.
// Lamp vectors are packed {red, yellow, green}.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GRN = 3'd0,
    NS_YEL = 3'd1,
    RED_A  = 3'd2,
    EW_GRN = 3'd3,
    EW_YEL = 3'd4,
    RED_B  = 3'd5
  } phase_t;

  typedef logic [2:0] lamp_t;

  localparam lamp_t LAMP_R = 3'b100;
  localparam lamp_t LAMP_Y = 3'b010;
  localparam lamp_t LAMP_G = 3'b001;

  localparam int CNT_W_DEF        = 5;
  localparam int NS_GREEN_MIN_DEF = 10;
  localparam int EW_GREEN_DEF     = 8;
  localparam int YELLOW_T_DEF     = 2;
  localparam int ALL_RED_T_DEF    = 1;

endpackage

// File: rtl/intersection_controller_if.sv
// Sensor/request inputs and lamp outputs of the intersection controller.
// master drives requests and watches lamps; slave is the controller.
interface intersection_controller_if;

  logic ew_car;
  logic ped_req;
  logic preempt;
  logic ns_red;
  logic ns_yellow;
  logic ns_green;
  logic ew_red;
  logic ew_yellow;
  logic ew_green;
  logic walk;
  logic ped_wait;

  modport master (
    output ew_car, ped_req, preempt,
    input  ns_red, ns_yellow, ns_green,
    input  ew_red, ew_yellow, ew_green,
    input  walk, ped_wait
  );

  modport slave (
    input  ew_car, ped_req, preempt,
    output ns_red, ns_yellow, ns_green,
    output ew_red, ew_yellow, ew_green,
    output walk, ped_wait
  );

endinterface

// File: rtl/phase_timer.sv
// Phase dwell counter: clears on request, counts up to a limit and holds.
// done is high while the count sits at the limit.
module phase_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (cnt_q < limit)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign done = (cnt_q == limit);

endmodule

// File: rtl/intersection_controller.sv
// NS-resting intersection sequencer with demand-served EW phase,
// latched pedestrian request and emergency preempt toward NS green.
module intersection_controller
  import traffic_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int NS_GREEN_MIN = NS_GREEN_MIN_DEF,
  parameter int EW_GREEN     = EW_GREEN_DEF,
  parameter int YELLOW_T     = YELLOW_T_DEF,
  parameter int ALL_RED_T    = ALL_RED_T_DEF
) (
  input logic clk,
  input logic reset,
  intersection_controller_if.slave io
);

  phase_t           state_q, state_d;
  logic             ped_q, ped_d;
  logic [CNT_W-1:0] limit;
  logic             done;
  logic             clr;
  logic             demand;
  lamp_t            ns_lamp, ew_lamp;
  logic             walk;

  always_comb begin
    limit = '0;
    unique case (state_q)
      NS_GRN:  limit = CNT_W'(NS_GREEN_MIN);
      NS_YEL:  limit = CNT_W'(YELLOW_T);
      RED_A:   limit = CNT_W'(ALL_RED_T);
      EW_GRN:  limit = CNT_W'(EW_GREEN);
      EW_YEL:  limit = CNT_W'(YELLOW_T);
      RED_B:   limit = CNT_W'(ALL_RED_T);
      default: limit = '0;
    endcase
  end

  assign demand = io.ew_car | ped_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      NS_GRN:  if (done && demand && !io.preempt)
                 state_d = NS_YEL;
      NS_YEL:  if (done) state_d = RED_A;
      RED_A:   if (done) state_d = EW_GRN;
      // preempt cuts EW green short; clearance states keep timing
      EW_GRN:  if (done || io.preempt)
                 state_d = EW_YEL;
      EW_YEL:  if (done) state_d = RED_B;
      RED_B:   if (done) state_d = NS_GRN;
      default: state_d = RED_B;
    endcase
  end

  assign clr = (state_d != state_q);

  always_comb begin
    ped_d = ped_q;
    if (io.ped_req && state_q != EW_GRN)
      ped_d = 1'b1;
    if (state_q != EW_GRN && state_d == EW_GRN)
      ped_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RED_B;
      ped_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ped_q   <= ped_d;
    end
  end

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .limit (limit),
    .done  (done)
  );

  always_comb begin
    ns_lamp = LAMP_R;
    ew_lamp = LAMP_R;
    walk    = 1'b0;
    unique case (1'b1)
      (state_q == NS_GRN): ns_lamp = LAMP_G;
      (state_q == NS_YEL): ns_lamp = LAMP_Y;
      (state_q == EW_GRN): begin
        ew_lamp = LAMP_G;
        walk    = 1'b1;
      end
      (state_q == EW_YEL): ew_lamp = LAMP_Y;
      default: ;
    endcase
  end

  assign io.ns_red    = ns_lamp[2];
  assign io.ns_yellow = ns_lamp[1];
  assign io.ns_green  = ns_lamp[0];
  assign io.ew_red    = ew_lamp[2];
  assign io.ew_yellow = ew_lamp[1];
  assign io.ew_green  = ew_lamp[0];
  assign io.walk      = walk;
  assign io.ped_wait  = ped_q;

endmodule

// File: tb/tb_intersection_controller.sv
// Bench: phase/age reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_intersection_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;

  intersection_controller_if io();

  intersection_controller dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model: phase index in service order 0..5 and cycles spent in it
  int dur [6] = '{11, 3, 2, 9, 3, 2};
  int m_ph    = 5;
  int m_age   = 1;
  bit m_pend  = 0;
  bit m_valid = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit leave;
    int nph;
    bit np;
    if (reset) begin
      m_ph = 5; m_age = 1; m_pend = 0; m_valid = 1;
    end else if (m_valid) begin
      case (m_ph)
        0: leave = (m_age >= dur[0]) && (io.ew_car || m_pend)
                   && !io.preempt;
        3: leave = (m_age >= dur[3]) || io.preempt;
        default: leave = (m_age >= dur[m_ph]);
      endcase
      nph = leave ? (m_ph + 1) % 6 : m_ph;
      np = m_pend | (io.ped_req && m_ph != 3);
      if (nph == 3 && m_ph != 3) np = 0;
      m_ph = nph;
      m_pend = np;
      m_age = leave ? 1 : (m_age < 100000 ? m_age + 1 : m_age);
    end
  end

  function automatic logic [31:0] exp_lamp(int grn, int yel);
    if (m_ph == grn) return 32'b001;
    if (m_ph == yel) return 32'b010;
    return 32'b100;
  endfunction

  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      chk("ns_lamps", {io.ns_red, io.ns_yellow, io.ns_green},
          exp_lamp(0, 1));
      chk("ew_lamps", {io.ew_red, io.ew_yellow, io.ew_green},
          exp_lamp(3, 4));
      chk("walk", io.walk, m_ph == 3);
      chk("ped_wait", io.ped_wait, m_pend);
      chk("safety", (io.ns_green | io.ns_yellow) &
                    (io.ew_green | io.ew_yellow), 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  int c0, c1, c2, c3, c4;

  initial begin
    io.ew_car = 0; io.ped_req = 0; io.preempt = 0;

    // 1: no demand -> 2 all-red cycles then NS green held
    do_reset();
    chk("t1_reset_out",
        {io.ns_red, io.ew_red, io.ns_green, io.walk, io.ped_wait},
        5'b11000);
    step();
    chk("t1_s1_allred", io.ns_red & io.ew_red, 1);
    step();
    c0 = 0;
    for (int i = 0; i < 100; i++) begin
      c0 += int'(io.ns_green);
      step();
    end
    chk("t1_ns_hold", c0, 100);

    // 2: constant EW demand -> 30-cycle loop
    io.ew_car = 1;
    do_reset();
    step(); step();
    c0 = 0; c1 = 0; c2 = 0; c3 = 0; c4 = 0;
    for (int i = 0; i < 60; i++) begin
      c0 += int'(io.ns_green);
      c1 += int'(io.ns_yellow);
      c2 += int'(io.ew_green);
      c3 += int'(io.ew_yellow);
      c4 += int'(io.ns_red & io.ew_red);
      step();
    end
    chk("t2_ns_green", c0, 22);
    chk("t2_ns_yel", c1, 6);
    chk("t2_ew_green", c2, 18);
    chk("t2_ew_yel", c3, 6);
    chk("t2_all_red", c4, 8);

    // 3: pedestrian request at NS green cycle 3
    io.ew_car = 0;
    do_reset();
    c0 = 0; c1 = 0; c2 = 0;
    for (int i = 1; i <= 31; i++) begin
      io.ped_req = (i == 5);
      step();
      io.ped_req = 0;
      if (i >= 2) begin
        c0 += int'(io.ns_green);
        c1 += int'(io.walk);
        c2 += int'(io.walk & io.ped_wait);
      end
      if (i == 5) chk("t3_wait_set", io.ped_wait, 1);
      if (i == 17) chk("t3_wait_red_a", io.ped_wait, 1);
      if (i == 18) chk("t3_walk_entry", {io.walk, io.ped_wait}, 2'b10);
    end
    chk("t3_ns_green", c0, 11);
    chk("t3_walk_len", c1, 9);
    chk("t3_wait_in_walk", c2, 0);

    // 4: request during EW green ignored
    io.ew_car = 1;
    do_reset();
    c0 = 0; c1 = 0;
    for (int i = 1; i <= 70; i++) begin
      if (i == 18) io.ew_car = 0;
      io.ped_req = (i == 21);
      step();
      io.ped_req = 0;
      if (i >= 21) c0 += int'(io.ped_wait);
      if (i >= 33) c1 += int'(io.ew_green);
    end
    chk("t4_no_wait", c0, 0);
    chk("t4_no_ew", c1, 0);
    chk("t4_ns_hold", io.ns_green, 1);

    // 5: preempt at EW green cycle 2
    io.ew_car = 1;
    do_reset();
    c0 = 0;
    for (int i = 1; i <= 60; i++) begin
      io.preempt = (i >= 20);
      step();
      if (i == 20) chk("t5_ew_yel", io.ew_yellow, 1);
      if (i == 22) chk("t5_ew_yel_end", io.ew_yellow, 1);
      if (i == 23) chk("t5_red_b", io.ns_red & io.ew_red, 1);
      if (i >= 25) c0 += int'(io.ns_green);
    end
    chk("t5_ns_hold", c0, 36);
    io.preempt = 0;

    // 6: reset during EW yellow with request pending
    io.ew_car = 1;
    do_reset();
    for (int i = 1; i <= 28; i++) begin
      io.ped_req = (i == 28);
      step();
    end
    io.ped_req = 0;
    chk("t6_pending", {io.ew_yellow, io.ped_wait}, 2'b11);
    do_reset();
    chk("t6_after_rst",
        {io.ns_red, io.ew_red, io.ew_yellow, io.ped_wait},
        4'b1100);

    // random traffic
    io.ew_car = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) io.ew_car = ~io.ew_car;
      io.ped_req = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 59) == 0) io.preempt = ~io.preempt;
      reset = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
